// File: rtl/stream_capture_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stream_capture_if : control + pixel/frame/line stream bundle for stream_capture
// Rev 1.0
// ----------------------------------------------------------------------------
interface stream_capture_if #(
   parameter int PIXEL_W = 8,
   parameter int COL_W   = 8,
   parameter int ROW_W   = 8,
   parameter int FCNT_W  = 4
);
   logic                Start;
   logic [FCNT_W-1:0]   NumFrames;
   logic [PIXEL_W-1:0]  PixelIn;
   logic                ValidIn;
   logic                FrameIn;
   logic                LineIn;
   logic [PIXEL_W-1:0]  DataOut;
   logic [COL_W-1:0]    I;
   logic [ROW_W-1:0]    J;
   logic                ValidOut;
   logic                FrameOut;
   logic [COL_W:0]      LineLen;
   logic                Busy;
   logic                Done;
   logic                Error;

   modport master (
      output Start, NumFrames, PixelIn, ValidIn, FrameIn, LineIn,
      input  DataOut, I, J, ValidOut, FrameOut, LineLen, Busy, Done, Error
   );

   modport slave (
      input  Start, NumFrames, PixelIn, ValidIn, FrameIn, LineIn,
      output DataOut, I, J, ValidOut, FrameOut, LineLen, Busy, Done, Error
   );
endinterface
`default_nettype wire

// File: rtl/stream_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stream_capture : armed multi-frame capture with column/row tagging and
//                  line-length consistency checking
// Rev 1.0
// ----------------------------------------------------------------------------
module stream_capture #(
   parameter int PIXEL_W = 8,
   parameter int COL_W   = 8,
   parameter int ROW_W   = 8,
   parameter int FCNT_W  = 4
) (
   input  wire logic        Clk,
   input  wire logic        nReset,
   stream_capture_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      CAPTURE  = 2'd2,
      DONE     = 2'd3
   } state_t;

   localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);
   localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
   localparam logic [COL_W:0]    LEN_ONE  = (COL_W + 1)'(1);

   state_t               state_q,   state_d;
   logic [FCNT_W-1:0]    nframes_q, nframes_d;
   logic [FCNT_W-1:0]    fcount_q,  fcount_d;
   logic [PIXEL_W-1:0]   data_q,    data_d;
   logic [COL_W-1:0]     i_q,       i_d;
   logic [ROW_W-1:0]     j_q,       j_d;
   logic                 valid_q,   valid_d;
   logic                 frame_q,   frame_d;
   logic [COL_W:0]       linelen_q, linelen_d;
   logic                 lenknown_q, lenknown_d;
   logic                 error_q,   error_d;

   logic [COL_W:0]       line_len_w;

   // i_q is the column of the last emitted pixel, so I+1 is the length of the line it closed
   assign line_len_w = {1'b0, i_q} + LEN_ONE;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q    <= IDLE;
         nframes_q  <= '0;
         fcount_q   <= '0;
         data_q     <= '0;
         i_q        <= '0;
         j_q        <= '0;
         valid_q    <= 1'b0;
         frame_q    <= 1'b0;
         linelen_q  <= '0;
         lenknown_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         nframes_q  <= nframes_d;
         fcount_q   <= fcount_d;
         data_q     <= data_d;
         i_q        <= i_d;
         j_q        <= j_d;
         valid_q    <= valid_d;
         frame_q    <= frame_d;
         linelen_q  <= linelen_d;
         lenknown_q <= lenknown_d;
         error_q    <= error_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      nframes_d  = nframes_q;
      fcount_d   = fcount_q;
      data_d     = data_q;
      i_d        = i_q;
      j_d        = j_q;
      valid_d    = 1'b0;
      frame_d    = 1'b0;
      linelen_d  = linelen_q;
      lenknown_d = lenknown_q;
      error_d    = error_q;

      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               nframes_d = bus.NumFrames;
               error_d   = 1'b0;
               fcount_d  = '0;
               linelen_d = '0;
               state_d   = WAIT_SOF;
            end
         end

         WAIT_SOF: begin
            // Zero frames requested: spend one Busy cycle here, then finish
            if (nframes_q == '0) begin
               state_d = DONE;
            end else if (bus.ValidIn && bus.FrameIn) begin
               valid_d    = 1'b1;
               frame_d    = 1'b1;
               data_d     = bus.PixelIn;
               i_d        = '0;
               j_d        = '0;
               fcount_d   = FCNT_ONE;
               lenknown_d = 1'b0;
               state_d    = CAPTURE;
            end
         end

         CAPTURE: begin
            if (bus.ValidIn) begin
               if (bus.FrameIn || bus.LineIn) begin
                  if (!lenknown_q) begin
                     linelen_d  = line_len_w;
                     lenknown_d = 1'b1;
                  end else if (line_len_w != linelen_q) begin
                     error_d = 1'b1;
                  end
               end

               if (bus.FrameIn) begin
                  if (fcount_q == nframes_q) begin
                     state_d = DONE;
                  end else begin
                     valid_d    = 1'b1;
                     frame_d    = 1'b1;
                     data_d     = bus.PixelIn;
                     i_d        = '0;
                     j_d        = '0;
                     fcount_d   = fcount_q + FCNT_ONE;
                     lenknown_d = 1'b0;
                  end
               end else if (bus.LineIn) begin
                  valid_d = 1'b1;
                  data_d  = bus.PixelIn;
                  i_d     = '0;
                  if (&j_q) begin
                     error_d = 1'b1;
                  end else begin
                     j_d = j_q + ROW_ONE;
                  end
               end else begin
                  valid_d = 1'b1;
                  data_d  = bus.PixelIn;
                  if (&i_q) begin
                     error_d = 1'b1;
                  end else begin
                     i_d = i_q + COL_ONE;
                  end
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.DataOut  = data_q;
   assign bus.I        = i_q;
   assign bus.J        = j_q;
   assign bus.ValidOut = valid_q;
   assign bus.FrameOut = frame_q;
   assign bus.LineLen  = linelen_q;
   assign bus.Busy     = (state_q == WAIT_SOF) || (state_q == CAPTURE);
   assign bus.Done     = (state_q == DONE);
   assign bus.Error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stream_capture : scoreboard bench for stream_capture
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_stream_capture;

   logic Clk    = 1'b0;
   logic nReset = 1'b0;

   always #5 Clk = ~Clk;

   stream_capture_if #(.PIXEL_W(8), .COL_W(8), .ROW_W(8), .FCNT_W(4)) bus ();
   stream_capture_if #(.PIXEL_W(8), .COL_W(2), .ROW_W(8), .FCNT_W(4)) sbus ();

   stream_capture #(.PIXEL_W(8), .COL_W(8), .ROW_W(8), .FCNT_W(4)) dut (
      .Clk    (Clk),
      .nReset (nReset),
      .bus    (bus)
   );

   stream_capture #(.PIXEL_W(8), .COL_W(2), .ROW_W(8), .FCNT_W(4)) dut_sat (
      .Clk    (Clk),
      .nReset (nReset),
      .bus    (sbus)
   );

   typedef struct {
      logic [7:0] d;
      logic [7:0] i;
      logic [7:0] j;
      logic       f;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_out    = 0;
   int   out_base;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
      end
   endtask

   // Scoreboard consumer: every ValidOut must match the oldest expected pixel
   always @(negedge Clk) begin
      if (bus.ValidOut === 1'b1) begin
         n_out++;
         if (sb.size() == 0) begin
            check_eq("unexpected_out", 32'(bus.ValidOut), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq("out_data",  32'(bus.DataOut),  32'(e.d));
            check_eq("out_i",     32'(bus.I),        32'(e.i));
            check_eq("out_j",     32'(bus.J),        32'(e.j));
            check_eq("out_frame", 32'(bus.FrameOut), 32'(e.f));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic px(input logic [7:0] d, input logic v, input logic f, input logic l);
      bus.PixelIn = d;
      bus.ValidIn = v;
      bus.FrameIn = f;
      bus.LineIn  = l;
      tick();
   endtask

   task automatic send_line(input int row, input int len, input bit fs, input int base,
                            input bit cap, input bit gap, input int arm_col);
      for (int c = 0; c < len; c++) begin
         bus.Start = (c == arm_col);
         if (cap) sb.push_back('{d: 8'(base + c), i: 8'(c), j: 8'(row), f: (fs && c == 0)});
         px(8'(base + c), 1'b1, fs && (c == 0), c == 0);
         bus.Start = 1'b0;
         if (gap) px(8'hEE, 1'b0, 1'b1, 1'b1);
      end
   endtask

   task automatic send_frame(input int h, input int w, input bit cap, input bit gap, input int arm_idx);
      for (int r = 0; r < h; r++) begin
         send_line(r, w, r == 0, r * w, cap, gap,
                   (arm_idx >= 0 && arm_idx / w == r) ? arm_idx % w : -1);
      end
   endtask

   task automatic end_frame(input string tag);
      px(8'hF0, 1'b1, 1'b1, 1'b1);
      bus.ValidIn = 1'b0;
      bus.FrameIn = 1'b0;
      bus.LineIn  = 1'b0;
      check_eq({tag, "_done"},  32'(bus.Done),     32'd1);
      check_eq({tag, "_busy"},  32'(bus.Busy),     32'd0);
      check_eq({tag, "_valid"}, 32'(bus.ValidOut), 32'd0);
   endtask

   task automatic check_reset_outs(input string tag);
      check_eq({tag, "_data"},    32'(bus.DataOut),  32'd0);
      check_eq({tag, "_i"},       32'(bus.I),        32'd0);
      check_eq({tag, "_j"},       32'(bus.J),        32'd0);
      check_eq({tag, "_valid"},   32'(bus.ValidOut), 32'd0);
      check_eq({tag, "_frame"},   32'(bus.FrameOut), 32'd0);
      check_eq({tag, "_linelen"}, 32'(bus.LineLen),  32'd0);
      check_eq({tag, "_busy"},    32'(bus.Busy),     32'd0);
      check_eq({tag, "_done"},    32'(bus.Done),     32'd0);
      check_eq({tag, "_error"},   32'(bus.Error),    32'd0);
   endtask

   initial begin
      bus.Start = 1'b0;  bus.NumFrames = '0;  bus.PixelIn = '0;
      bus.ValidIn = 1'b0; bus.FrameIn = 1'b0; bus.LineIn = 1'b0;
      sbus.Start = 1'b0; sbus.NumFrames = '0; sbus.PixelIn = '0;
      sbus.ValidIn = 1'b0; sbus.FrameIn = 1'b0; sbus.LineIn = 1'b0;

      repeat (3) @(posedge Clk);
      #1;
      check_reset_outs("reset");
      nReset = 1'b1;
      tick();

      // Basic: two 4x3 frames, then a terminating frame start
      out_base = n_out;
      bus.NumFrames = 4'd2;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      check_eq("basic_busy_after_start", 32'(bus.Busy), 32'd1);
      send_frame(3, 4, 1'b1, 1'b0, -1);
      send_frame(3, 4, 1'b1, 1'b0, -1);
      end_frame("basic");
      check_eq("basic_linelen",   32'(bus.LineLen),   32'd4);
      check_eq("basic_error",     32'(bus.Error),     32'd0);
      check_eq("basic_out_count", 32'(n_out - out_base), 32'd24);
      tick();
      check_eq("basic_done_pulse", 32'(bus.Done), 32'd0);

      // Arm in the middle of a frame: nothing until the next frame start
      bus.NumFrames = 4'd1;
      send_frame(3, 4, 1'b0, 1'b0, 5);
      check_eq("arm_busy", 32'(bus.Busy), 32'd1);
      send_frame(3, 4, 1'b1, 1'b0, -1);
      end_frame("arm");
      tick();

      // Gapped stream, with a Start while busy that must be ignored
      out_base = n_out;
      bus.NumFrames = 4'd2;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      bus.NumFrames = 4'd7;
      send_frame(3, 4, 1'b1, 1'b1, 6);
      send_frame(3, 4, 1'b1, 1'b1, -1);
      end_frame("gap");
      check_eq("gap_out_count", 32'(n_out - out_base), 32'd24);
      tick();

      // Short last line: 4,4,3
      bus.NumFrames = 4'd1;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      send_line(0, 4, 1'b1, 0, 1'b1, 1'b0, -1);
      send_line(1, 4, 1'b0, 4, 1'b1, 1'b0, -1);
      send_line(2, 3, 1'b0, 8, 1'b1, 1'b0, -1);
      check_eq("short_err_before", 32'(bus.Error), 32'd0);
      end_frame("short");
      check_eq("short_err", 32'(bus.Error), 32'd1);
      tick();
      check_eq("short_err_sticky", 32'(bus.Error),   32'd1);
      check_eq("short_linelen",    32'(bus.LineLen), 32'd4);

      // NumFrames=0: Error cleared by Start, Done two cycles after Start
      bus.NumFrames = 4'd0;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      check_eq("zero_err_clear", 32'(bus.Error), 32'd0);
      check_eq("zero_busy",      32'(bus.Busy),  32'd1);
      check_eq("zero_done_early", 32'(bus.Done), 32'd0);
      tick();
      check_eq("zero_done", 32'(bus.Done), 32'd1);
      check_eq("zero_busy_end", 32'(bus.Busy), 32'd0);
      tick();
      check_eq("zero_done_pulse", 32'(bus.Done), 32'd0);

      // Column saturation on the COL_W=2 instance
      sbus.NumFrames = 4'd1;
      sbus.Start = 1'b1;
      tick();
      sbus.Start = 1'b0;
      for (int c = 0; c < 6; c++) begin
         sbus.PixelIn = 8'(c + 32);
         sbus.ValidIn = 1'b1;
         sbus.FrameIn = (c == 0);
         sbus.LineIn  = (c == 0);
         tick();
         check_eq("sat_valid", 32'(sbus.ValidOut), 32'd1);
         check_eq("sat_data",  32'(sbus.DataOut),  32'(c + 32));
         check_eq("sat_i",     32'(sbus.I),        (c > 3) ? 32'd3 : 32'(c));
         check_eq("sat_error", 32'(sbus.Error),    (c >= 4) ? 32'd1 : 32'd0);
      end
      sbus.FrameIn = 1'b1;
      sbus.LineIn  = 1'b1;
      tick();
      sbus.ValidIn = 1'b0;
      sbus.FrameIn = 1'b0;
      sbus.LineIn  = 1'b0;
      check_eq("sat_done", 32'(sbus.Done), 32'd1);

      // Asynchronous reset in the middle of a capture
      bus.NumFrames = 4'd3;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      send_line(0, 4, 1'b1, 0, 1'b1, 1'b0, -1);
      send_line(1, 2, 1'b0, 4, 1'b1, 1'b0, -1);
      bus.ValidIn = 1'b0;
      tick();
      nReset = 1'b0;
      #2;
      check_reset_outs("rst_mid");
      tick();
      nReset = 1'b1;
      send_frame(3, 4, 1'b0, 1'b0, -1);
      bus.ValidIn = 1'b0;
      tick();
      check_eq("rst_busy_after", 32'(bus.Busy), 32'd0);
      check_eq("sb_drained",     32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
